// File: rtl/jedro_1_ifu.sv
// jedro_1_ifu: instruction fetch unit.
// Issues one word fetch at a time, buffers responses in a small prefetch
// FIFO tagged with their PC, and handles redirects by flushing the FIFO and
// discarding any response that belongs to a request made before the redirect.
module jedro_1_ifu #(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        jmp_instr_i,
  input  logic [31:0] jmp_address_i,
  output logic [31:0] instr_rdata_o,
  output logic [31:0] instr_addr_o,
  output logic        instr_valid_o,
  input  logic        dec_ready_i
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t        state_q, state_n;
  logic [31:0]   fetch_pc_q, fetch_pc_n;  // next address to request
  logic [31:0]   addr_q, addr_n;          // address of the current/last request
  logic          discard_q, discard_n;    // outstanding response is stale
  logic [CW-1:0] count_q, count_n;
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [31:0]   data_mem [FIFO_DEPTH];
  logic [31:0]   addr_mem [FIFO_DEPTH];

  logic [31:0] jmp_tgt;
  logic        rvalid_w, push, pop;

  assign jmp_tgt  = jmp_address_i & 32'hFFFF_FFFC;
  assign rvalid_w = (state_q == S_WAIT) && mem_rvalid_i;
  // a redirect drops whatever arrives or leaves the FIFO in the same cycle
  assign push     = rvalid_w && !discard_q && !jmp_instr_i;
  assign pop      = instr_valid_o && dec_ready_i && !jmp_instr_i;

  assign mem_req_o     = (state_q == S_REQ);
  assign mem_addr_o    = addr_q;
  assign instr_valid_o = (count_q != '0);
  assign instr_rdata_o = instr_valid_o ? data_mem[rd_ptr_q] : 32'h0;
  assign instr_addr_o  = instr_valid_o ? addr_mem[rd_ptr_q] : 32'h0;

  // FIFO occupancy after this cycle's push/pop/flush
  always_comb begin
    count_n = count_q;
    if (jmp_instr_i)        count_n = '0;
    else if (push && !pop)  count_n = count_q + CW'(1);
    else if (pop && !push)  count_n = count_q - CW'(1);
  end

  // fetch sequencing: next state, next PC, request address and discard flag
  always_comb begin
    state_n    = state_q;
    fetch_pc_n = fetch_pc_q;
    addr_n     = addr_q;
    discard_n  = discard_q;

    // a stale grant does not advance the PC: it already holds the target
    if (state_q == S_REQ && mem_gnt_i && !discard_q) fetch_pc_n = addr_q + 32'd4;
    if (jmp_instr_i) fetch_pc_n = jmp_tgt;

    if (rvalid_w) discard_n = 1'b0;
    // only a response still to come can be marked stale
    if (jmp_instr_i && (state_q == S_REQ || (state_q == S_WAIT && !mem_rvalid_i)))
      discard_n = 1'b1;

    case (state_q)
      S_IDLE:  if (count_n < DEPTH) state_n = S_REQ;
      S_REQ:   if (mem_gnt_i) state_n = S_WAIT;
      S_WAIT:  if (mem_rvalid_i) state_n = (count_n < DEPTH) ? S_REQ : S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // address is latched on entry to REQ and held until granted
    if (state_n == S_REQ && state_q != S_REQ) addr_n = fetch_pc_n;
  end

  // control state registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= BOOT_ADDR;
      addr_q     <= BOOT_ADDR;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_n;
      fetch_pc_q <= fetch_pc_n;
      addr_q     <= addr_n;
      discard_q  <= discard_n;
    end
  end

  // FIFO pointers and count; a redirect empties the buffer
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_n;
      if (jmp_instr_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  // FIFO storage; contents are masked at the outputs while empty
  always_ff @(posedge clk_i) begin
    if (push) begin
      data_mem[wr_ptr_q] <= mem_rdata_i;
      addr_mem[wr_ptr_q] <= addr_q;
    end
  end

endmodule

// File: tb/tb_jedro_1_ifu.sv
// tb_jedro_1_ifu: directed scenarios plus random traffic for jedro_1_ifu.
// Reference: requests are tagged with a redirect epoch; only responses of the
// current epoch reach a queue of {pc, data}, and fresh fetches must walk
// target, target+4, ... from the last redirect or reset.
module tb_jedro_1_ifu;
  localparam int          FD   = 4;
  localparam logic [31:0] BOOT = 32'h0000_0000;

  logic        clk_i = 1'b0, rstn_i = 1'b1;
  logic        mem_req_o, mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
  logic [31:0] mem_addr_o, mem_rdata_i = 32'h0;
  logic        jmp_instr_i = 1'b0, dec_ready_i = 1'b0, instr_valid_o;
  logic [31:0] jmp_address_i = 32'h0, instr_rdata_o, instr_addr_o;

  jedro_1_ifu #(.BOOT_ADDR(BOOT), .FIFO_DEPTH(FD)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .jmp_instr_i(jmp_instr_i), .jmp_address_i(jmp_address_i),
    .instr_rdata_o(instr_rdata_o), .instr_addr_o(instr_addr_o),
    .instr_valid_o(instr_valid_o), .dec_ready_i(dec_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] a; logic [31:0] d; } ent_t;

  int total = 0, bad = 0;
  ent_t q[$];
  logic [31:0] glog[$];
  int epoch = 0, req_tag = 0, out_tag = 0;
  bit req_live = 0, out_live = 0, prev_hold = 0;
  logic [31:0] exp_fetch = BOOT, out_addr = 0, prev_addr = 0;
  bit mem_pend = 0; int mem_dly = 0; logic [31:0] mem_paddr = 0;
  int gnt_pct = 100, rdy_pct = 100, jmp_pct = 0, rv_min = 0, rv_max = 0;
  bit force_jmp = 0; logic [31:0] force_tgt = 0;
  int cyc = 0, first_gnt = -1, first_vld = -1, ngnt = 0, npop = 0;
  bit cap_arm = 0, cap_g_got = 0, cap_i_got = 0;
  logic [31:0] cap_g = '1, cap_i = '1, a_hold = 0;
  int p0;

  // memory image: word n holds "addi xn, x0, n"
  function automatic logic [31:0] f(input logic [31:0] a);
    return (a >> 2) * 32'h0010_0080 + 32'h13;
  endfunction

  function automatic ent_t mk(input logic [31:0] a);
    ent_t e;
    e.a = a; e.d = f(a);
    return e;
  endfunction

  function automatic logic [31:0] rand_tgt();
    if ($urandom_range(3) == 0) return 32'hFFFF_FFF0 | 32'($urandom_range(15));
    return 32'($urandom_range(4095));
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic arm();
    cap_arm = 1; cap_g_got = 0; cap_i_got = 0; cap_g = '1; cap_i = '1;
  endtask

  task automatic reset_model();
    q.delete(); epoch++; exp_fetch = BOOT;
    req_live = 0; out_live = 0; mem_pend = 0; prev_hold = 0;
  endtask

  // one clock: check outputs, drive inputs, advance reference, cross edge
  task automatic step();
    bit pop_now, fresh;
    chk32("instr_valid", 32'(instr_valid_o), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk32("instr_addr", instr_addr_o, q[0].a);
      chk32("instr_rdata", instr_rdata_o, q[0].d);
    end else begin
      chk32("empty_addr", instr_addr_o, 32'h0);
      chk32("empty_rdata", instr_rdata_o, 32'h0);
    end
    if (prev_hold) begin
      chk32("req_hold", 32'(mem_req_o), 32'd1);
      chk32("addr_hold", mem_addr_o, prev_addr);
    end
    if (mem_req_o) begin
      chk32("one_outstanding", 32'(out_live), 32'd0);
      chk32("req_space", 32'(q.size() < FD), 32'd1);
      if (!req_live) begin req_live = 1; req_tag = epoch; end
    end
    if (cap_arm && !cap_i_got && instr_valid_o) begin cap_i = instr_addr_o; cap_i_got = 1; end
    if (first_vld < 0 && instr_valid_o) first_vld = cyc;

    mem_rvalid_i  = mem_pend && (mem_dly == 0);
    mem_rdata_i   = mem_rvalid_i ? f(mem_paddr) : $urandom;
    mem_gnt_i     = mem_req_o && (int'($urandom_range(99)) < gnt_pct);
    jmp_instr_i   = force_jmp || (int'($urandom_range(99)) < jmp_pct);
    jmp_address_i = force_jmp ? force_tgt : rand_tgt();
    force_jmp     = 0;
    dec_ready_i   = int'($urandom_range(99)) < rdy_pct;

    pop_now = instr_valid_o && dec_ready_i && !jmp_instr_i && (q.size() != 0);
    if (pop_now) begin void'(q.pop_front()); npop++; end
    if (mem_rvalid_i) begin
      if (out_live && out_tag == epoch && !jmp_instr_i) q.push_back(mk(out_addr));
      out_live = 0; mem_pend = 0;
    end else if (mem_pend) mem_dly--;
    if (mem_gnt_i) begin
      fresh = (req_tag == epoch) && !jmp_instr_i;
      if (fresh) begin
        chk32("fetch_addr", mem_addr_o, exp_fetch);
        exp_fetch += 32'd4;
        ngnt++;
        glog.push_back(mem_addr_o);
        if (first_gnt < 0) first_gnt = cyc;
        if (cap_arm && !cap_g_got) begin cap_g = mem_addr_o; cap_g_got = 1; end
      end
      out_live = 1; out_tag = req_tag; out_addr = mem_addr_o; req_live = 0;
      mem_pend = 1; mem_paddr = mem_addr_o;
      mem_dly = int'($urandom_range(32'(rv_max), 32'(rv_min)));
    end
    if (jmp_instr_i) begin
      q.delete(); epoch++; exp_fetch = jmp_address_i & 32'hFFFF_FFFC;
    end
    prev_hold = mem_req_o && !mem_gnt_i;
    prev_addr = mem_addr_o;
    @(posedge clk_i); #1; cyc++;
  endtask

  // asynchronous reset, optionally with a response arriving across it
  task automatic do_reset(input bit rv);
    rstn_i = 0; mem_gnt_i = 0; jmp_instr_i = 0; dec_ready_i = 0;
    mem_rvalid_i = rv; mem_rdata_i = 32'hDEAD_BEEF;
    #1;
    chk32("rst_req", 32'(mem_req_o), 32'd0);
    chk32("rst_addr", mem_addr_o, BOOT);
    chk32("rst_valid", 32'(instr_valid_o), 32'd0);
    chk32("rst_rdata", instr_rdata_o, 32'h0);
    chk32("rst_iaddr", instr_addr_o, 32'h0);
    @(posedge clk_i); @(posedge clk_i); @(negedge clk_i);
    rstn_i = 1;
    reset_model();
    @(posedge clk_i); #1; cyc++;
    chk32("boot_req", 32'(mem_req_o), 32'd1);
    chk32("boot_addr", mem_addr_o, BOOT);
    if (rv) begin
      @(posedge clk_i); #1; cyc++;
      chk32("post_rst_req", 32'(mem_req_o), 32'd1);
      chk32("post_rst_addr", mem_addr_o, BOOT);
      chk32("post_rst_valid", 32'(instr_valid_o), 32'd0);
    end
    mem_rvalid_i = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #3;
    do_reset(0);

    // in-order fetch with immediate grant and one-cycle response
    gnt_pct = 100; rdy_pct = 100; rv_min = 0; rv_max = 0;
    glog.delete(); first_gnt = -1; first_vld = -1;
    repeat (12) step();
    chk32("gnt_to_valid", 32'(first_vld - first_gnt), 32'd2);
    chk32("fetch0", glog[0], 32'h0);
    chk32("fetch1", glog[1], 32'h4);
    chk32("fetch2", glog[2], 32'h8);

    // decoder stalled: buffer fills, then one pop frees one fetch
    do_reset(0);
    rdy_pct = 0; rv_max = 2; ngnt = 0;
    repeat (30) step();
    chk32("full_fetches", 32'(ngnt), 32'd4);
    chk32("full_req", 32'(mem_req_o), 32'd0);
    chk32("full_valid", 32'(instr_valid_o), 32'd1);
    chk32("full_head", instr_addr_o, 32'h0);
    p0 = npop; rdy_pct = 100; step(); rdy_pct = 0; arm();
    repeat (15) step();
    chk32("one_pop", 32'(npop - p0), 32'd1);
    chk32("refill_fetches", 32'(ngnt), 32'd5);
    chk32("refill_addr", cap_g, 32'h10);

    // redirect while a response is pending
    rdy_pct = 100; gnt_pct = 100; rv_min = 1; rv_max = 2;
    for (int i = 0; i < 40 && !mem_pend; i++) step();
    chk32("reach_wait", 32'(mem_pend), 32'd1);
    force_jmp = 1; force_tgt = 32'h0000_0103; step(); arm();
    repeat (15) step();
    chk32("jmp_wait_fetch", cap_g, 32'h100);
    chk32("jmp_wait_instr", cap_i, 32'h100);

    // redirect while the request is held off by the memory
    gnt_pct = 0; rv_min = 0;
    for (int i = 0; i < 40 && !mem_req_o; i++) step();
    chk32("reach_req", 32'(mem_req_o), 32'd1);
    a_hold = mem_addr_o;
    step(); force_jmp = 1; force_tgt = 32'h0000_0200; step(); step();
    chk32("held_req", 32'(mem_req_o), 32'd1);
    chk32("held_addr", mem_addr_o, a_hold);
    gnt_pct = 100; arm();
    repeat (15) step();
    chk32("jmp_req_fetch", cap_g, 32'h200);
    chk32("jmp_req_instr", cap_i, 32'h200);

    // push and pop together with three entries buffered
    rdy_pct = 0; rv_min = 0; rv_max = 0;
    force_jmp = 1; force_tgt = 32'h0000_0300; step();
    for (int i = 0; i < 40 && !(q.size() == 3 && mem_pend); i++) step();
    chk32("reach_three", 32'(q.size() == 3 && mem_pend), 32'd1);
    rdy_pct = 100; gnt_pct = 0; p0 = npop;
    step();
    chk32("pushpop_head", instr_addr_o, 32'h304);
    repeat (8) step();
    chk32("pushpop_drain", 32'(npop - p0), 32'd4);
    chk32("pushpop_empty", 32'(instr_valid_o), 32'd0);

    // reset in the middle of an outstanding fetch
    gnt_pct = 100; rdy_pct = 100; rv_min = 2; rv_max = 2;
    for (int i = 0; i < 40 && !mem_pend; i++) step();
    chk32("reach_wait2", 32'(mem_pend), 32'd1);
    do_reset(1);
    rv_min = 0; arm();
    repeat (12) step();
    chk32("rst_fetch", cap_g, BOOT);
    chk32("rst_instr", cap_i, BOOT);

    // random traffic
    gnt_pct = 60; rdy_pct = 50; jmp_pct = 4; rv_min = 0; rv_max = 3;
    repeat (2000) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
